// File: rtl/prefetch_unit.sv
// prefetch_unit
//   Instruction-fetch stage with a DEPTH-entry prefetch queue. Requests go out
//   in order over a ready/valid memory port. Responses come back in order with
//   any latency >= 1 and are paired with the PC recorded at issue. A branch
//   redirect flushes the queue. Responses still owed for flushed requests are
//   counted in `discard` and dropped silently when they arrive.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   redirect_valid  flush and restart at redirect_pc (highest priority)
//   redirect_pc     restart address; bits [1:0] are forced to zero
//   imem_req_*      fetch request (valid/ready, addr = fetch_pc)
//   imem_rsp_*      in-order instruction return (no back-pressure)
//   if_valid/ready  head-of-queue handshake toward execute
//   if_instr/if_pc  head instruction and its PC; NOP / 0 when if_valid=0
module prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    typedef logic [AW:0] ptr_t;

    localparam ptr_t            PTR_ONE    = ptr_t'(1);
    localparam logic [AW+1:0]   DEPTH_CNT  = (AW+2)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    ptr_t            alloc_ptr, fill_ptr, rd_ptr;
    ptr_t            discard;
    logic [DEPTH-1:0] filled;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    ptr_t            allocated, inflight, discard_next;
    logic [AW+1:0]   used;
    logic [AW-1:0]   alloc_idx, fill_idx, rd_idx;
    logic            req_fire, rsp_keep, pop;

    assign allocated = alloc_ptr - rd_ptr;
    assign inflight  = alloc_ptr - fill_ptr;
    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];

    // Every queue slot and every stale response still owed by memory uses one
    // credit. Counting both keeps pending memory transactions at DEPTH or fewer.
    assign used = {1'b0, allocated} + {1'b0, discard};

    // Gating with reset forces the request low as soon as reset is asserted,
    // without waiting for a clock edge.
    assign imem_req_valid = reset && !redirect_valid && (used < DEPTH_CNT);
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (discard == '0);

    // The head is presented only from registered state, so a response
    // accepted in cycle N becomes visible in cycle N+1.
    assign if_valid = filled[rd_idx] && (allocated != '0);
    assign if_instr = if_valid ? instr_mem[rd_idx] : NOP;
    assign if_pc    = if_valid ? pc_mem[rd_idx]    : '0;
    assign pop      = if_valid && if_ready && !redirect_valid;

    // On a redirect, everything still in flight becomes stale. A response that
    // arrives in the redirect cycle is one of those and is dropped at once.
    assign discard_next = discard + inflight - ptr_t'(imem_rsp_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            discard   <= '0;
            filled    <= '0;
        end else if (redirect_valid) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            filled    <= '0;
            fetch_pc  <= redirect_pc & ALIGN_MASK;
            discard   <= discard_next;
        end else begin
            // Allocation, fill and pop can never target the same slot in one
            // cycle, so the order of these updates does not matter.
            if (req_fire) begin
                filled[alloc_idx] <= 1'b0;
                alloc_ptr         <= alloc_ptr + PTR_ONE;
                fetch_pc          <= fetch_pc + XLEN'(4);
            end
            if (imem_rsp_valid) begin
                if (discard != '0) begin
                    discard <= discard - PTR_ONE;
                end else begin
                    filled[fill_idx] <= 1'b1;
                    fill_ptr         <= fill_ptr + PTR_ONE;
                end
            end
            if (pop) begin
                filled[rd_idx] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_ONE;
            end
        end
    end

    // The payload storage needs no reset. It is read only through filled
    // entries, and those are always written before they are marked filled.
    always_ff @(posedge clk) begin
        if (req_fire) pc_mem[alloc_idx] <= fetch_pc;
        if (rsp_keep) instr_mem[fill_idx] <= imem_rsp_data;
    end

    // A response is legal only when a request is outstanding or a stale
    // response is owed.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (discard != '0 || inflight != '0));

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    prefetch_unit dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mem_q[$];
    exp_t        sb[$];
    int unsigned cyc;
    int          mem_lat;
    logic [31:0] model_pc;
    int          n_vec;
    int          n_bad;

    // Observations of the cycle completed by the last step()
    logic        obs_rv, obs_rdy, obs_req, obs_pop, obs_v;
    logic [31:0] obs_addr, exp_addr, obs_pc, obs_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    // Advance one clock. The memory model answers each accepted request
    // mem_lat cycles later. Each handshake pushes the expected {pc, instr}
    // of the fetch onto the scoreboard.
    task automatic step();
        mreq_t m;
        exp_t  e;
        #1;
        obs_rv    = imem_req_valid;
        obs_rdy   = imem_req_ready;
        obs_req   = imem_req_valid && imem_req_ready;
        obs_addr  = imem_req_addr;
        exp_addr  = model_pc;
        obs_v     = if_valid;
        obs_pop   = if_valid && if_ready && !redirect_valid;
        obs_pc    = if_pc;
        obs_instr = if_instr;
        if (obs_req) begin
            m.due = cyc + mem_lat; m.addr = imem_req_addr;
            mem_q.push_back(m);
            e.pc = model_pc; e.instr = mem_word(model_pc);
            sb.push_back(e);
            model_pc = model_pc + 32'd4;
        end
        if (redirect_valid) begin
            sb.delete();
            model_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        @(posedge clk); #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(m.addr);
        end
    endtask

    task automatic apply_reset(input int lat);
        reset = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        if_ready = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mem_q.delete(); sb.delete();
        model_pc = RESET_PC; mem_lat = lat;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        if_ready = 1'b1; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mem_q.delete(); sb.delete();
        model_pc = RESET_PC; mem_lat = 1;
        #1;
        n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
        n_vec++; if (if_instr !== NOP) begin n_bad++; $display("FAIL reset_if_instr got=%h want=%h", if_instr, NOP); end
        n_vec++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc got=%h want=0", if_pc); end
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_bad++; $display("FAIL release_req got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    // Continues from test_reset: 1-cycle memory, if_ready held high.
    task automatic test_stream();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            step();
            n_vec++; if (!obs_req || obs_addr !== exp_addr || obs_addr !== 32'(i * 4)) begin
                n_bad++; $display("FAIL stream_req[%0d] got v=%b a=%h want v=1 a=%h", i, obs_req, obs_addr, 32'(i * 4));
            end
            if (i >= 2) begin
                n_vec++; if (!obs_pop) begin n_bad++; $display("FAIL stream_bubble[%0d] got pop=0 want 1", i); end
            end
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL stream_pop unexpected pc=%h", obs_pc); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                        n_bad++; $display("FAIL stream_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
            end
        end
    endtask

    task automatic test_full();
        exp_t e;
        int   hs;
        apply_reset(1);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_req) hs++;
            if (i >= 2) begin
                n_vec++; if (!obs_v || obs_pc !== 32'h0) begin
                    n_bad++; $display("FAIL full_head[%0d] got v=%b pc=%h want v=1 pc=0", i, obs_v, obs_pc);
                end
            end
        end
        n_vec++; if (hs != 4) begin n_bad++; $display("FAIL full_handshakes got=%0d want=4", hs); end
        #1;
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_valid got=%b want=0", imem_req_valid); end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        n_vec++;
        if (!obs_pop || sb.size() == 0) begin n_bad++; $display("FAIL full_pop got pop=%b want 1", obs_pop); end
        else begin
            e = sb.pop_front();
            if (obs_pc !== e.pc || obs_instr !== e.instr || obs_pc !== 32'h0) begin
                n_bad++; $display("FAIL full_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
            end
        end
        step();
        n_vec++; if (!obs_req || obs_addr !== 32'h10) begin
            n_bad++; $display("FAIL full_refill got v=%b a=%h want v=1 a=00000010", obs_req, obs_addr);
        end
        step();
        n_vec++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL full_single_credit got req=%b want 0", obs_req); end
    endtask

    task automatic test_redirect();
        exp_t e;
        int   npop;
        apply_reset(4);
        if_ready = 1'b1;
        repeat (3) step();
        // Three requests outstanding, none returned yet.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0104;
        step();
        n_vec++; if (obs_rv !== 1'b0) begin n_bad++; $display("FAIL redir_req_in_cycle got=%b want 0", obs_rv); end
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_if_valid got=%b want 0", if_valid); end
        npop = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 0) begin
                n_vec++; if (!obs_req || obs_addr !== 32'h104) begin
                    n_bad++; $display("FAIL redir_addr got v=%b a=%h want v=1 a=00000104", obs_req, obs_addr);
                end
            end
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL redir_pop unexpected pc=%h instr=%h", obs_pc, obs_instr); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr || (npop == 0 && obs_pc !== 32'h104)) begin
                        n_bad++; $display("FAIL redir_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
                npop++;
            end
        end
        n_vec++; if (npop < 4) begin n_bad++; $display("FAIL redir_progress got pops=%0d want >=4", npop); end
    endtask

    task automatic test_redirect_pop();
        exp_t e;
        apply_reset(1);
        repeat (2) step();
        n_vec++; if (if_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL rp_setup got v=%b rsp=%b want 1 1", if_valid, imem_rsp_valid);
        end
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        n_vec++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
            n_bad++; $display("FAIL rp_flush got v=%b instr=%h pc=%h want 0 %h 0", if_valid, if_instr, if_pc, NOP);
        end
        step();
        n_vec++; if (!obs_req || obs_addr !== 32'h40) begin
            n_bad++; $display("FAIL rp_addr got v=%b a=%h want v=1 a=00000040", obs_req, obs_addr);
        end
        n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rp_empty got v=%b want 0", if_valid); end
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rp_pop unexpected pc=%h", obs_pc); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                        n_bad++; $display("FAIL rp_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
            end
        end
    endtask

    task automatic test_pc_align_wrap();
        exp_t        e;
        logic [31:0] first_pcs[2];
        int          npop;
        apply_reset(1);
        if_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        step();
        redirect_valid = 1'b0;
        step();
        n_vec++; if (!obs_req || obs_addr !== 32'h200) begin
            n_bad++; $display("FAIL align_addr got v=%b a=%h want v=1 a=00000200", obs_req, obs_addr);
        end
        repeat (3) step();
        sb.delete();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        npop = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 2) begin
                n_vec++; if (!obs_req || obs_addr !== (i == 0 ? 32'hFFFF_FFFC : 32'h0)) begin
                    n_bad++; $display("FAIL wrap_addr[%0d] got v=%b a=%h want v=1 a=%h", i, obs_req, obs_addr, (i == 0 ? 32'hFFFF_FFFC : 32'h0));
                end
            end
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL wrap_pop unexpected pc=%h", obs_pc); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                        n_bad++; $display("FAIL wrap_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
                if (npop < 2) first_pcs[npop] = obs_pc;
                npop++;
            end
        end
        n_vec++; if (npop < 2 || first_pcs[0] !== 32'hFFFF_FFFC || first_pcs[1] !== 32'h0) begin
            n_bad++; $display("FAIL wrap_head got n=%0d pc0=%h pc1=%h want fffffffc 00000000", npop, first_pcs[0], first_pcs[1]);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        apply_reset(1);
        repeat (3) step();
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_bad++; $display("FAIL midrst_setup got v=%b pc=%h want v=1 pc=0", if_valid, if_pc);
        end
        #2;
        reset = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mem_q.delete(); sb.delete();
        model_pc = RESET_PC;
        #1;
        n_vec++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
            n_bad++; $display("FAIL midrst_async got v=%b req=%b instr=%h pc=%h want 0 0 %h 0", if_valid, imem_req_valid, if_instr, if_pc, NOP);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                n_vec++; if (!obs_req || obs_addr !== RESET_PC) begin
                    n_bad++; $display("FAIL midrst_restart got v=%b a=%h want v=1 a=%h", obs_req, obs_addr, RESET_PC);
                end
            end
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL midrst_pop unexpected pc=%h", obs_pc); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                        n_bad++; $display("FAIL midrst_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        prev_stall;
        logic [31:0] prev_addr;
        apply_reset(2);
        prev_stall = 1'b0; prev_addr = '0;
        for (int i = 0; i < 100; i++) begin
            imem_req_ready = ($urandom % 4) != 0;
            if_ready       = ($urandom % 2) != 0;
            step();
            if (prev_stall && obs_rv) begin
                n_vec++; if (obs_addr !== prev_addr) begin
                    n_bad++; $display("FAIL b2b_addr_stable[%0d] got=%h want=%h", i, obs_addr, prev_addr);
                end
            end
            if (obs_req) begin
                n_vec++; if (obs_addr !== exp_addr) begin
                    n_bad++; $display("FAIL b2b_addr[%0d] got=%h want=%h", i, obs_addr, exp_addr);
                end
            end
            prev_stall = obs_rv && !obs_rdy;
            prev_addr  = obs_addr;
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_pop unexpected pc=%h", obs_pc); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                        n_bad++; $display("FAIL b2b_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
            end
        end
        imem_req_ready = 1'b0; if_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_pop) begin
                n_vec++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL drain_pop unexpected pc=%h", obs_pc); end
                else begin
                    e = sb.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                        n_bad++; $display("FAIL drain_pop got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.instr);
                    end
                end
            end
        end
        n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL drain_empty got left=%0d want 0", sb.size()); end
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_pop();
        test_pc_align_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
